// File: rtl/uart_rx_frontend_pkg.sv
// Shared widths, defaults and helpers for the UART receive front end.
package uart_rx_frontend_pkg;

    localparam int unsigned DL_W          = 16;
    localparam int unsigned BRK_W         = 8;
    localparam int unsigned BRK_TICKS_DEF = 160;

    // Two-of-three vote used by the line filter.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[1] & s[2]) | (s[0] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x baud tick generator: down-counter that reloads dl-1 and pulses enable at terminal count.
module uart_baud_gen
    import uart_rx_frontend_pkg::*;
(
    input  logic            clk,
    input  logic            wb_rst_i,
    input  logic [DL_W-1:0] dl,
    input  logic            dl_wr,
    output logic            enable
);

    logic [DL_W-1:0] cnt_q;
    logic [DL_W-1:0] cnt_d;
    logic            init_q;
    logic            enable_d;

    // init_q forces a silent reload on the first edge after reset, exactly like a dl_wr.
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cnt_q  <= '0;
            init_q <= 1'b1;
            enable <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            init_q <= 1'b0;
            enable <= enable_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        enable_d = 1'b0;
        if (dl == '0) begin
            cnt_d = '0;
        end else if (dl_wr || init_q) begin
            cnt_d = dl - DL_W'(1);
        end else if (cnt_q == '0) begin
            cnt_d    = dl - DL_W'(1);
            enable_d = 1'b1;
        end else begin
            cnt_d = cnt_q - DL_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: baud tick, pin synchroniser, 3-sample majority filter,
// falling-edge detect and break detection.
module uart_rx_frontend
    import uart_rx_frontend_pkg::*;
#(
    parameter int unsigned BRK_TICKS = BRK_TICKS_DEF
) (
    input  logic            clk,
    input  logic            wb_rst_i,
    input  logic [DL_W-1:0] dl,
    input  logic            dl_wr,
    input  logic            srx_pad_i,
    output logic            enable,
    output logic            srx_o,
    output logic            rx_fall,
    output logic            break_o
);

    localparam logic [BRK_W-1:0] BRK_LIM = BRK_W'(BRK_TICKS);

    logic             sync1;
    logic             sync2;
    logic [2:0]       samp_q;
    logic             en_dly;
    logic             srx_dly;
    logic [BRK_W-1:0] brk_q;
    logic [BRK_W-1:0] brk_d;
    logic             break_d;

    uart_baud_gen u_baud_gen (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .dl       (dl),
        .dl_wr    (dl_wr),
        .enable   (enable)
    );

    // Samples shift on the tick; srx_o votes on them one clk later.
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            samp_q  <= 3'b111;
            en_dly  <= 1'b0;
            srx_o   <= 1'b1;
            srx_dly <= 1'b1;
            brk_q   <= '0;
            break_o <= 1'b0;
        end else begin
            sync1   <= srx_pad_i;
            sync2   <= sync1;
            en_dly  <= enable;
            srx_dly <= srx_o;
            brk_q   <= brk_d;
            break_o <= break_d;
            if (enable) begin
                samp_q <= {samp_q[1:0], sync2};
            end
            if (en_dly) begin
                srx_o <= maj3(samp_q);
            end
        end
    end

    // Break counter: saturates while the filtered line reads low on ticks.
    always_comb begin
        brk_d = brk_q;
        if (enable) begin
            if (srx_o) begin
                brk_d = '0;
            end else if (brk_q != BRK_LIM) begin
                brk_d = brk_q + BRK_W'(1);
            end
        end
        break_d = (brk_d == BRK_LIM);
    end

    assign rx_fall = srx_dly & ~srx_o;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: tick timing, filter, edge and break behaviour.
module tb_uart_rx_frontend;

    logic        clk;
    logic        wb_rst_i;
    logic [15:0] dl;
    logic        dl_wr;
    logic        srx_pad_i;
    logic        enable;
    logic        srx_o;
    logic        rx_fall;
    logic        break_o;

    int checks;
    int errors;

    uart_rx_frontend dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .dl        (dl),
        .dl_wr     (dl_wr),
        .srx_pad_i (srx_pad_i),
        .enable    (enable),
        .srx_o     (srx_o),
        .rx_fall   (rx_fall),
        .break_o   (break_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_enable"},  32'(enable),  32'd0);
        check({tag, "_srx"},     32'(srx_o),   32'd1);
        check({tag, "_rx_fall"}, 32'(rx_fall), 32'd0);
        check({tag, "_break"},   32'(break_o), 32'd0);
    endtask

    initial begin
        int en_cnt;
        int bad;
        checks    = 0;
        errors    = 0;
        wb_rst_i  = 1'b0;
        dl        = 16'd4;
        dl_wr     = 1'b0;
        srx_pad_i = 1'b1;

        step(3);
        check_reset_vals("reset");

        // dl=4, idle line: enable in cycles 4, 8, 12 after release.
        wb_rst_i = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step(1);
            check("dl4_enable", 32'(enable), 32'((c % 4 == 0) && (c > 0)));
        end
        check("dl4_srx", 32'(srx_o), 32'd1);
        check("dl4_rx_fall", 32'(rx_fall), 32'd0);

        // dl=0 holds enable low.
        dl = 16'd0;
        en_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (enable) en_cnt++;
        end
        check("dl0_no_enable", 32'(en_cnt), 32'd0);

        // dl=2 written: suppressed on the write, then every 2 clk.
        dl    = 16'd2;
        dl_wr = 1'b1;
        step(1);
        dl_wr = 1'b0;
        check("dl2_wr_cycle", 32'(enable), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check("dl2_enable", 32'(enable), 32'(i % 2 == 0));
        end

        // dl=1: tick every cycle.
        dl    = 16'd1;
        dl_wr = 1'b1;
        step(1);
        dl_wr = 1'b0;
        check("dl1_wr_cycle", 32'(enable), 32'd0);
        step(1);
        check("dl1_enable", 32'(enable), 32'd1);
        step(4);

        // One-tick glitch must be filtered out.
        srx_pad_i = 1'b0;
        step(1);
        srx_pad_i = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            if (srx_o !== 1'b1 || rx_fall !== 1'b0) bad++;
        end
        check("glitch_filtered", 32'(bad), 32'd0);

        // Held low: srx_o falls 4 clk after the pin, rx_fall for one clk.
        srx_pad_i = 1'b0;
        step(3);
        check("fall_p2_srx", 32'(srx_o), 32'd1);
        step(1);
        check("fall_p3_srx", 32'(srx_o), 32'd1);
        check("fall_p3_rx_fall", 32'(rx_fall), 32'd0);
        step(1);
        check("fall_p4_srx", 32'(srx_o), 32'd0);
        check("fall_p4_rx_fall", 32'(rx_fall), 32'd1);
        step(1);
        check("fall_p5_rx_fall", 32'(rx_fall), 32'd0);
        check("fall_p5_break", 32'(break_o), 32'd0);

        // Break asserts on the 160th low tick and stays saturated.
        step(158);
        check("brk_159", 32'(break_o), 32'd0);
        step(1);
        check("brk_160", 32'(break_o), 32'd1);
        step(5);
        check("brk_hold", 32'(break_o), 32'd1);

        // Line returns high: break clears on the first high-sampled tick.
        srx_pad_i = 1'b1;
        step(4);
        check("rise_q3_srx", 32'(srx_o), 32'd0);
        check("rise_q3_break", 32'(break_o), 32'd1);
        step(1);
        check("rise_q4_srx", 32'(srx_o), 32'd1);
        check("rise_q4_break", 32'(break_o), 32'd1);
        check("rise_q4_rx_fall", 32'(rx_fall), 32'd0);
        step(1);
        check("rise_q5_break", 32'(break_o), 32'd0);

        // Reset mid-character with the line low.
        srx_pad_i = 1'b0;
        step(6);
        check("midchar_srx_low", 32'(srx_o), 32'd0);
        #2 wb_rst_i = 1'b0;
        #1;
        check_reset_vals("midrst");
        dl = 16'd3;
        step(2);
        check_reset_vals("midrst_held");
        wb_rst_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1);
            check("post_rst_enable", 32'(enable), 32'(c == 3));
            check("post_rst_srx", 32'(srx_o), 32'd1);
            check("post_rst_rx_fall", 32'(rx_fall), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
